// File: rtl/paula_audio_pkg.sv
// Shared Paula audio definitions: mixer sample width, I2S slot/frame geometry
// and the slot-widening helper used when a stereo frame is captured.
package paula_audio_pkg;

  localparam int SAMPLE_W   = 15;
  localparam int SLOT_W     = 16;
  localparam int FRAME_BITS = 32;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [BIT_W-1:0] BIT_LAST = 5'd31;

  typedef logic [SAMPLE_W-1:0]   sample_t;
  typedef logic [SLOT_W-1:0]     slot_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Left-justify a mixer word into its slot; a muted capture yields silence.
  function automatic slot_t widen(input sample_t s, input logic en);
    slot_t r;
    if (en) begin
      r = {s, 1'b0};
    end else begin
      r = {SLOT_W{1'b0}};
    end
    return r;
  endfunction

endpackage

// File: rtl/paula_audio_i2s_tx_if.sv
// Mixer-side sample handshake plus the I2S pins of the Paula audio transmitter.
interface paula_audio_i2s_tx_if;
  import paula_audio_pkg::*;

  logic    en;
  sample_t ldatasum;
  sample_t rdatasum;
  logic    sample_req;
  logic    bclk;
  logic    lrck;
  logic    sdata;

  modport master (
    output en, ldatasum, rdatasum,
    input  sample_req, bclk, lrck, sdata
  );

  modport slave (
    input  en, ldatasum, rdatasum,
    output sample_req, bclk, lrck, sdata
  );

endinterface

// File: rtl/paula_audio_bclk_gen.sv
// I2S bit-clock divider: toggles bclk every CLK_DIV clk and flags the clk
// whose closing edge takes bclk from 1 to 0.
module paula_audio_bclk_gen #(
  parameter int unsigned CLK_DIV = 9
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_r;
  logic       bclk_r;
  logic       terminal_s;

  // Terminal-count decode and falling-edge strobe (suppressed under reset)
  always_comb begin
    terminal_s = (div_cnt_r == DIV_LAST);
    fall       = terminal_s & bclk_r & ~reset;
    bclk       = bclk_r;
  end

  // Divider counter and bit-clock register
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= 8'd0;
      bclk_r    <= 1'b0;
    end else if (terminal_s) begin
      div_cnt_r <= 8'd0;
      bclk_r    <= ~bclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/paula_audio_i2s_tx.sv
// Paula audio I2S transmitter: captures one stereo mixer sample per 32-bit
// frame and serializes it MSB first with the standard one-bit I2S offset.
module paula_audio_i2s_tx
  import paula_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 9
) (
  input logic               clk,
  input logic               reset,
  paula_audio_i2s_tx_if.slave bus
);

  logic             fall_s;
  logic             bclk_s;
  logic             capture_s;
  logic [BIT_W-1:0] next_bit_s;
  frame_t           next_shreg_s;

  logic [BIT_W-1:0] bit_cnt_r;
  logic             lrck_r;
  logic             sdata_r;
  frame_t           shreg_r;

  paula_audio_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk   (clk),
    .reset (reset),
    .bclk  (bclk_s),
    .fall  (fall_s)
  );

  // Falling-edge next state: load a fresh frame entering bit 0, else shift
  always_comb begin
    next_bit_s   = bit_cnt_r + 5'd1;
    capture_s    = 1'b0;
    next_shreg_s = {FRAME_BITS{1'b0}};
    if (fall_s && (bit_cnt_r == BIT_LAST)) begin
      capture_s    = 1'b1;
      next_shreg_s = {widen(bus.ldatasum, bus.en), widen(bus.rdatasum, bus.en)};
    end else begin
      next_shreg_s = {shreg_r[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Frame state; everything moves only on bclk falling edges
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r <= BIT_LAST;
      lrck_r    <= CH_RIGHT;
      sdata_r   <= 1'b0;
      shreg_r   <= {FRAME_BITS{1'b0}};
    end else if (fall_s) begin
      bit_cnt_r <= next_bit_s;
      lrck_r    <= next_bit_s[BIT_W-1];
      // The old MSB goes out now, giving the one-bclk delay behind lrck.
      sdata_r   <= shreg_r[FRAME_BITS-1];
      shreg_r   <= next_shreg_s;
    end else begin
      bit_cnt_r <= bit_cnt_r;
      lrck_r    <= lrck_r;
      sdata_r   <= sdata_r;
      shreg_r   <= shreg_r;
    end
  end

  // Drive the I2S pins and the capture request onto the bus
  always_comb begin
    bus.bclk       = bclk_s;
    bus.lrck       = lrck_r;
    bus.sdata      = sdata_r;
    bus.sample_req = capture_s;
  end

endmodule
